// File: rtl/id_ctrl_unit.sv
// id_ctrl_unit
// Decode-stage controller for a 5-stage pipeline. It decodes the IF/ID instruction,
// selects the immediate format and registers the ID/EX control bundle. It also stalls
// on load-use hazards for a configurable number of bubbles and squashes the wrong-path
// instruction on a taken branch. Saturating stall/flush performance counters are included.
module id_ctrl_unit #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned PERF_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic              branch_taken,
  output logic [1:0]        imm_sel,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op,
  output logic [4:0]        ex_rd,
  output logic              illegal_instr,
  output logic [PERF_W-1:0] stall_count,
  output logic [PERF_W-1:0] flush_count
);

  // Opcodes understood by the decoder
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // Immediate generator selects; 11 makes the generator output zero
  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  // ALU operation classes
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Number of extra STALL cycles after the hazard cycle itself
  localparam logic [2:0] STALL_LOAD = 3'(LOAD_USE_BUBBLES - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // ID/EX control bundle; the all-zero value is the bubble
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
    logic [4:0] rd;
  } ex_bundle_t;

  localparam ex_bundle_t BUBBLE = '0;

  // Instruction fields
  logic [6:0] opcode_s;
  logic [4:0] rd_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic       unused_instr_bits_s;

  assign opcode_s = id_instr[6:0];
  assign rd_s     = id_instr[11:7];
  assign rs1_s    = id_instr[19:15];
  assign rs2_s    = id_instr[24:20];

  // funct3/funct7 are consumed by the EX-stage ALU decoder, not here
  assign unused_instr_bits_s = ^{id_instr[31:25], id_instr[14:12]};

  // Decoder outputs
  ex_bundle_t dec_bundle_s;
  logic [1:0] dec_imm_sel_s;
  logic       dec_use_rs1_s;
  logic       dec_use_rs2_s;
  logic       dec_illegal_s;

  // Combinational opcode decode; unknown opcodes become a NOP and are flagged illegal
  always_comb begin
    dec_bundle_s       = BUBBLE;
    dec_bundle_s.valid = 1'b1;
    dec_bundle_s.rd    = rd_s;
    dec_imm_sel_s      = IMM_NONE;
    dec_use_rs1_s      = 1'b0;
    dec_use_rs2_s      = 1'b0;
    dec_illegal_s      = 1'b0;
    case (opcode_s)
      OP_R: begin
        dec_bundle_s.reg_write = 1'b1;
        dec_bundle_s.alu_op    = ALU_FUNCT;
        dec_use_rs1_s          = 1'b1;
        dec_use_rs2_s          = 1'b1;
      end
      OP_I: begin
        dec_bundle_s.reg_write = 1'b1;
        dec_bundle_s.alu_op    = ALU_FUNCT;
        dec_bundle_s.alu_src   = 1'b1;
        dec_imm_sel_s          = IMM_I;
        dec_use_rs1_s          = 1'b1;
      end
      OP_LD: begin
        dec_bundle_s.reg_write = 1'b1;
        dec_bundle_s.mem_read  = 1'b1;
        dec_bundle_s.alu_op    = ALU_ADD;
        dec_bundle_s.alu_src   = 1'b1;
        dec_imm_sel_s          = IMM_I;
        dec_use_rs1_s          = 1'b1;
      end
      OP_ST: begin
        dec_bundle_s.mem_write = 1'b1;
        dec_bundle_s.alu_op    = ALU_ADD;
        dec_bundle_s.alu_src   = 1'b1;
        dec_imm_sel_s          = IMM_S;
        dec_use_rs1_s          = 1'b1;
        dec_use_rs2_s          = 1'b1;
      end
      OP_BR: begin
        dec_bundle_s.branch = 1'b1;
        dec_bundle_s.alu_op = ALU_SUB;
        dec_imm_sel_s       = IMM_B;
        dec_use_rs1_s       = 1'b1;
        dec_use_rs2_s       = 1'b1;
      end
      default: begin
        // NOP: no controls, no register use, no destination
        dec_bundle_s.rd = 5'd0;
        dec_illegal_s   = 1'b1;
      end
    endcase
  end

  assign imm_sel = dec_imm_sel_s;

  // Registered state
  state_t                  state_q;
  logic [2:0]              cnt_q;
  ex_bundle_t              ex_q;
  logic                    illegal_q;
  logic [PERF_W-1:0]       stall_cnt_q;
  logic [PERF_W-1:0]       flush_cnt_q;

  // Load-use hazard: the instruction in EX is a load whose rd is a source of the ID instruction
  logic hazard_s;
  assign hazard_s = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                    ((dec_use_rs1_s & (rs1_s == ex_q.rd)) |
                     (dec_use_rs2_s & (rs2_s == ex_q.rd)));

  // Front-end hold/flush controls; a taken branch overrides any stall
  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    if (branch_taken) begin
      ifid_flush = 1'b1;
    end else if ((state_q == ST_STALL) || hazard_s) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
    end
  end

  // RUN/STALL sequencer and ID/EX bundle register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= 3'd0;
      ex_q      <= BUBBLE;
      illegal_q <= 1'b0;
    end else if (branch_taken) begin
      // Squash: wrong-path instruction never reaches EX
      state_q   <= ST_RUN;
      cnt_q     <= 3'd0;
      ex_q      <= BUBBLE;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard_s) begin
            ex_q      <= BUBBLE;
            illegal_q <= 1'b0;
            if (LOAD_USE_BUBBLES > 1) begin
              state_q <= ST_STALL;
              cnt_q   <= STALL_LOAD;
            end else begin
              state_q <= ST_RUN;
              cnt_q   <= 3'd0;
            end
          end else if (id_valid) begin
            ex_q      <= dec_bundle_s;
            illegal_q <= dec_illegal_s;
          end else begin
            ex_q      <= BUBBLE;
            illegal_q <= 1'b0;
          end
        end
        ST_STALL: begin
          ex_q      <= BUBBLE;
          illegal_q <= 1'b0;
          cnt_q     <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_STALL;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          cnt_q     <= 3'd0;
          ex_q      <= BUBBLE;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters for stall cycles and taken-branch flushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
      if (branch_taken && (flush_cnt_q != {PERF_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_branch     = ex_q.branch;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_rd         = ex_q.rd;
  assign illegal_instr = illegal_q;
  assign stall_count   = stall_cnt_q;
  assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_id_ctrl_unit.sv
// Directed bench for id_ctrl_unit: one instance with a single load-use bubble and
// 16-bit counters, one with three bubbles and 2-bit counters (to reach saturation).
module tb_id_ctrl_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Instance A: LOAD_USE_BUBBLES=1, PERF_W=16
  logic [31:0] a_instr = 32'd0;
  logic        a_valid = 1'b0;
  logic        a_branch = 1'b0;
  logic [1:0]  a_imm_sel, a_alu_op;
  logic        a_pc_stall, a_ifid_stall, a_ifid_flush;
  logic        a_ex_valid, a_rw, a_mr, a_mw, a_src, a_br, a_illegal;
  logic [4:0]  a_rd;
  logic [15:0] a_stall_cnt, a_flush_cnt;

  // Instance B: LOAD_USE_BUBBLES=3, PERF_W=2
  logic [31:0] b_instr = 32'd0;
  logic        b_valid = 1'b0;
  logic        b_branch = 1'b0;
  logic [1:0]  b_imm_sel, b_alu_op;
  logic        b_pc_stall, b_ifid_stall, b_ifid_flush;
  logic        b_ex_valid, b_rw, b_mr, b_mw, b_src, b_br, b_illegal;
  logic [4:0]  b_rd;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  id_ctrl_unit #(.LOAD_USE_BUBBLES(1), .PERF_W(16)) u_a (
    .clk(clk), .rst(rst), .id_instr(a_instr), .id_valid(a_valid), .branch_taken(a_branch),
    .imm_sel(a_imm_sel), .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall),
    .ifid_flush(a_ifid_flush), .ex_valid(a_ex_valid), .ex_reg_write(a_rw),
    .ex_mem_read(a_mr), .ex_mem_write(a_mw), .ex_alu_src(a_src), .ex_branch(a_br),
    .ex_alu_op(a_alu_op), .ex_rd(a_rd), .illegal_instr(a_illegal),
    .stall_count(a_stall_cnt), .flush_count(a_flush_cnt)
  );

  id_ctrl_unit #(.LOAD_USE_BUBBLES(3), .PERF_W(2)) u_b (
    .clk(clk), .rst(rst), .id_instr(b_instr), .id_valid(b_valid), .branch_taken(b_branch),
    .imm_sel(b_imm_sel), .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall),
    .ifid_flush(b_ifid_flush), .ex_valid(b_ex_valid), .ex_reg_write(b_rw),
    .ex_mem_read(b_mr), .ex_mem_write(b_mw), .ex_alu_src(b_src), .ex_branch(b_br),
    .ex_alu_op(b_alu_op), .ex_rd(b_rd), .illegal_instr(b_illegal),
    .stall_count(b_stall_cnt), .flush_count(b_flush_cnt)
  );

  localparam logic [31:0] ADDI_X1   = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] LW_X2     = 32'h0000A103; // lw   x2,0(x1)
  localparam logic [31:0] ADD_X3    = 32'h004101B3; // add  x3,x2,x4
  localparam logic [31:0] LW_X0     = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X3_X0 = 32'h000001B3; // add  x3,x0,x0
  localparam logic [31:0] SW_X2     = 32'h0020A023; // sw   x2,0(x1)
  localparam logic [31:0] BEQ_X1X2  = 32'h00208063; // beq  x1,x2,0
  localparam logic [31:0] BAD_OP    = 32'h0000007F;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #3;
    chk("rst_a_ex_valid", 32'(a_ex_valid), 32'd0);
    chk("rst_a_stall_cnt", 32'(a_stall_cnt), 32'd0);
    chk("rst_a_pc_stall", 32'(a_pc_stall), 32'd0);
    chk("rst_b_illegal", 32'(b_illegal), 32'd0);
    rst = 1'b0;

    // ---------------- A: ADDI decode ----------------
    a_instr = ADDI_X1; a_valid = 1'b1;
    #1;
    chk("addi_imm_sel", 32'(a_imm_sel), 32'd0);
    chk("addi_no_stall", 32'(a_pc_stall), 32'd0);
    tick();
    chk("addi_ex_valid", 32'(a_ex_valid), 32'd1);
    chk("addi_rw", 32'(a_rw), 32'd1);
    chk("addi_src", 32'(a_src), 32'd1);
    chk("addi_alu_op", 32'(a_alu_op), 32'd2);
    chk("addi_rd", 32'(a_rd), 32'd1);
    chk("addi_mr", 32'(a_mr), 32'd0);

    // ---------------- A: LW then dependent ADD, one bubble ----------------
    a_instr = LW_X2;
    tick();
    chk("lw_mr", 32'(a_mr), 32'd1);
    chk("lw_rd", 32'(a_rd), 32'd2);
    chk("lw_alu_op", 32'(a_alu_op), 32'd0);
    a_instr = ADD_X3;
    #1;
    chk("lu1_pc_stall", 32'(a_pc_stall), 32'd1);
    chk("lu1_ifid_stall", 32'(a_ifid_stall), 32'd1);
    chk("lu1_no_flush", 32'(a_ifid_flush), 32'd0);
    tick();
    chk("lu1_bubble_valid", 32'(a_ex_valid), 32'd0);
    chk("lu1_bubble_rw", 32'(a_rw), 32'd0);
    chk("lu1_stall_cnt", 32'(a_stall_cnt), 32'd1);
    #1;
    chk("lu1_stall_release", 32'(a_pc_stall), 32'd0);
    tick();
    chk("lu1_add_valid", 32'(a_ex_valid), 32'd1);
    chk("lu1_add_rd", 32'(a_rd), 32'd3);
    chk("lu1_add_src", 32'(a_src), 32'd0);
    chk("lu1_stall_cnt_hold", 32'(a_stall_cnt), 32'd1);

    // ---------------- A: store and branch decode ----------------
    a_instr = SW_X2;
    #1;
    chk("sw_imm_sel", 32'(a_imm_sel), 32'd1);
    tick();
    chk("sw_mw", 32'(a_mw), 32'd1);
    chk("sw_rw", 32'(a_rw), 32'd0);
    a_instr = BEQ_X1X2;
    #1;
    chk("beq_imm_sel", 32'(a_imm_sel), 32'd2);
    tick();
    chk("beq_br", 32'(a_br), 32'd1);
    chk("beq_alu_op", 32'(a_alu_op), 32'd1);
    chk("beq_src", 32'(a_src), 32'd0);

    // ---------------- A: illegal opcode ----------------
    a_instr = BAD_OP;
    #1;
    chk("ill_imm_sel", 32'(a_imm_sel), 32'd3);
    tick();
    chk("ill_pulse", 32'(a_illegal), 32'd1);
    chk("ill_nop_rw", 32'(a_rw), 32'd0);
    chk("ill_nop_mr", 32'(a_mr), 32'd0);
    chk("ill_nop_alu_op", 32'(a_alu_op), 32'd0);
    a_valid = 1'b0;
    tick();
    chk("ill_invalid_no_pulse", 32'(a_illegal), 32'd0);
    chk("invalid_bubble", 32'(a_ex_valid), 32'd0);

    // ---------------- A: flush of an illegal opcode ----------------
    a_valid = 1'b1; a_branch = 1'b1;
    #1;
    chk("flush_a_ifid_flush", 32'(a_ifid_flush), 32'd1);
    tick();
    a_branch = 1'b0;
    chk("flush_a_no_illegal", 32'(a_illegal), 32'd0);
    chk("flush_a_count", 32'(a_flush_cnt), 32'd1);
    a_instr = ADDI_X1;
    tick();
    chk("a_reload_valid", 32'(a_ex_valid), 32'd1);

    // ---------------- B: LW then ADD with three bubbles ----------------
    b_instr = LW_X2; b_valid = 1'b1;
    tick();
    b_instr = ADD_X3;
    #1;
    chk("lu3_stall_c1", 32'(b_pc_stall), 32'd1);
    tick();
    chk("lu3_bubble1", 32'(b_ex_valid), 32'd0);
    chk("lu3_stall_c2", 32'(b_pc_stall), 32'd1);
    tick();
    chk("lu3_bubble2", 32'(b_ex_valid), 32'd0);
    chk("lu3_stall_c3", 32'(b_ifid_stall), 32'd1);
    tick();
    chk("lu3_bubble3", 32'(b_ex_valid), 32'd0);
    chk("lu3_release", 32'(b_pc_stall), 32'd0);
    chk("lu3_stall_cnt", 32'(b_stall_cnt), 32'd3);
    tick();
    chk("lu3_add_valid", 32'(b_ex_valid), 32'd1);
    chk("lu3_add_rd", 32'(b_rd), 32'd3);

    // ---------------- B: load to x0 never stalls ----------------
    b_instr = LW_X0;
    tick();
    b_instr = ADD_X3_X0;
    #1;
    chk("lw_x0_no_stall", 32'(b_pc_stall), 32'd0);
    tick();
    chk("lw_x0_add_valid", 32'(b_ex_valid), 32'd1);

    // ---------------- B: branch during STALL, counter saturation ----------------
    b_instr = LW_X2;
    tick();
    b_instr = ADD_X3;
    tick();
    #1;
    chk("br_in_stall_pre", 32'(b_pc_stall), 32'd1);
    b_branch = 1'b1;
    #1;
    chk("br_in_stall_flush", 32'(b_ifid_flush), 32'd1);
    chk("br_in_stall_pc", 32'(b_pc_stall), 32'd0);
    chk("br_in_stall_ifid", 32'(b_ifid_stall), 32'd0);
    tick();
    b_branch = 1'b0; b_valid = 1'b0;
    chk("br_in_stall_bubble", 32'(b_ex_valid), 32'd0);
    chk("br_flush_cnt", 32'(b_flush_cnt), 32'd1);
    chk("stall_cnt_saturated", 32'(b_stall_cnt), 32'd3);
    #1;
    chk("br_back_to_run", 32'(b_pc_stall), 32'd0);

    // ---------------- async reset in the middle of a stall ----------------
    b_instr = LW_X2; b_valid = 1'b1;
    tick();
    b_instr = ADD_X3;
    tick();
    chk("mid_stall_pre", 32'(b_pc_stall), 32'd1);
    chk("mid_stall_a_valid_pre", 32'(a_ex_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc_stall", 32'(b_pc_stall), 32'd0);
    chk("arst_b_stall_cnt", 32'(b_stall_cnt), 32'd0);
    chk("arst_b_flush_cnt", 32'(b_flush_cnt), 32'd0);
    chk("arst_a_ex_valid", 32'(a_ex_valid), 32'd0);
    chk("arst_a_rw", 32'(a_rw), 32'd0);
    chk("arst_a_rd", 32'(a_rd), 32'd0);
    chk("arst_a_stall_cnt", 32'(a_stall_cnt), 32'd0);
    chk("arst_a_flush_cnt", 32'(a_flush_cnt), 32'd0);
    #2;
    rst = 1'b0;
    b_instr = ADDI_X1;
    tick();
    chk("post_rst_b_load", 32'(b_ex_valid), 32'd1);
    chk("post_rst_b_no_stall", 32'(b_pc_stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
